basic_op_sequencer: RTL
=======================

// Module: basic_op_sequencer
//
// PURPOSE
//  Initiator and checker for the 2-bit bitwise logic unit (AND/OR/XOR/NOR, select s).
//  Accepts one operand pair over a valid/ready request channel.
//  Drives the logic unit's a/b/s inputs through all four selects on consecutive cycles,
//  samples each result and returns them packed on a valid/ready response channel.
//  Compares every sampled result against an internal golden model and reports a
//  per-op mismatch mask. Sits between the test/control fabric and the logic unit.
//
// PARAMETERS
//  WIDTH  2  operand/result width in bits; all ops are bitwise over WIDTH bits
//
// PORTS
//  clk           in   1         rising-edge clock
//  rst_n         in   1         asynchronous active-low reset
//  req_valid     in   1         request operands valid
//  req_ready     out  1         block can accept a request
//  req_a         in   WIDTH     operand a
//  req_b         in   WIDTH     operand b
//  op_a          out  WIDTH     operand a driven to logic unit
//  op_b          out  WIDTH     operand b driven to logic unit
//  op_s          out  2         select to logic unit: 00 AND, 01 OR, 10 XOR, 11 NOR
//  op_res        in   WIDTH     logic unit result for current op_s (combinational, same cycle)
//  rsp_valid     out  1         response valid
//  rsp_ready     in   1         response consumer ready
//  rsp_data      out  4*WIDTH   rsp_data[s*WIDTH +: WIDTH] = sampled result for select s
//  rsp_err_mask  out  4         bit s set = sampled result for select s != golden model
//
// BEHAVIOUR
//  Reset (async assert, sync deassert by clk):
//  - state=IDLE; req_ready=0 during reset, 1 from first clk edge after release.
//  - All other outputs 0 (op_a, op_b, op_s=00, rsp_valid, rsp_data, rsp_err_mask).
//  FSM states: IDLE, ISSUE, RESP. 2-bit op counter cnt.
//  IDLE:
//  - req_ready=1.
//  - On req_valid&&req_ready: register req_a/req_b into op_a/op_b, cnt=00, go to ISSUE.
//  ISSUE:
//  - req_ready=0; op_s=cnt.
//  - At each clk edge: write op_res into rsp_data[cnt], set err bit cnt if op_res != golden
//    (a&b, a|b, a^b, ~(a|b) per cnt), then cnt++.
//  - After cnt==11 is sampled, go to RESP. ISSUE lasts exactly 4 cycles.
//  RESP:
//  - rsp_valid=1; rsp_data and rsp_err_mask held stable; op_s holds 11.
//  - On rsp_valid&&rsp_ready: go to IDLE, rsp_valid=0 next cycle.
//  Sequencing and latency:
//  - Accept at cycle 0; op_s 00,01,10,11 on cycles 1-4; rsp_valid from cycle 5.
//  - With rsp_ready=1 throughout, next accept at cycle 6 earliest (no IDLE bypass).
//  Holding and stalls:
//  - op_a/op_b hold the captured operands until the next accept.
//  - rsp_data/rsp_err_mask hold until overwritten during the next ISSUE.
//  - req_valid during ISSUE/RESP is ignored (not accepted, not queued).
//  - rsp_ready during IDLE/ISSUE has no effect. rsp_ready held low stalls RESP indefinitely.
//  Reset mid-operation: in-flight transaction discarded, no response produced, all outputs as reset.
//  Width: all compares are full WIDTH bits; NOR uses bitwise complement truncated to WIDTH.
//
// TESTING
//  1. Ideal unit, a=2'b10, b=2'b11 -> op_s 00/01/10/11 on cycles 1-4;
//     cycle 5 rsp_valid=1, rsp_data=8'b00_01_11_10, rsp_err_mask=4'b0000.
//  2. Backpressure: rsp_ready=0 for 3 cycles in RESP, req_valid=1 -> rsp_valid/rsp_data stable,
//     req_ready=0, no new accept; accept only 1 cycle after rsp handshake.
//  3. Faulty unit (op_res stuck 2'b00), a=2'b01, b=2'b10 -> rsp_data=8'h00, rsp_err_mask=4'b0110.
//  4. Assert rst_n=0 while op_s=10 -> all outputs 0 immediately, no rsp_valid;
//     next request a=11, b=01 returns 8'b00_10_11_01 with mask 0000.
//  5. req_valid held high, rsp_ready=1, two requests -> accepts at cycles 0 and 6,
//     rsp_valid at cycles 5 and 11.
//  6. WIDTH=4, a=4'hA, b=4'h6, ideal unit -> rsp_data=16'h1CE2, rsp_err_mask=4'b0000.

Source files
------------

// File: rtl/basic_op_sequencer.sv
// Request/response initiator that walks a bitwise logic unit through AND/OR/XOR/NOR
// for one operand pair, captures each result and flags disagreements with a golden model.
module basic_op_sequencer #(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic [1:0]           op_s,
    input  logic [WIDTH-1:0]     op_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*WIDTH-1:0]   rsp_data,
    output logic [3:0]           rsp_err_mask
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_alive;
    logic [1:0]         r_cnt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [4*WIDTH-1:0] r_rsp_data;
    logic [3:0]         r_err_mask;
    logic [WIDTH-1:0]   w_golden;
    logic               w_accept;
    logic               w_mismatch;

    // r_alive keeps req_ready low while reset is held and for no longer.
    // NOTE: sequential state is written with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_alive <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ISSUE;
            ISSUE:   if (r_cnt == 2'd3) w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        op_s      = 2'b00;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE:  req_ready = r_alive;
            ISSUE: op_s      = r_cnt;
            RESP: begin
                op_s      = 2'b11;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_accept = req_valid && req_ready;

    // Golden model for the select currently presented to the unit.
    always_comb begin
        w_golden = '0;
        case (r_cnt)
            2'd0: w_golden = r_op_a & r_op_b;
            2'd1: w_golden = r_op_a | r_op_b;
            2'd2: w_golden = r_op_a ^ r_op_b;
            2'd3: w_golden = ~(r_op_a | r_op_b);
            default: ;
        endcase
    end

    assign w_mismatch = (op_res != w_golden);

    // Result slots are overwritten one per ISSUE cycle; stale slots stay visible until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 2'd0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rsp_data <= '0;
            r_err_mask <= 4'b0000;
        end else begin
            if (w_accept) begin
                r_op_a <= req_a;
                r_op_b <= req_b;
                r_cnt  <= 2'd0;
            end else if (r_state == ISSUE) begin
                for (int s = 0; s < 4; s++) begin
                    if (r_cnt == s[1:0]) r_rsp_data[s*WIDTH +: WIDTH] <= op_res;
                end
                r_err_mask[r_cnt] <= w_mismatch;
                r_cnt             <= r_cnt + 2'd1;
            end
        end
    end

    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign rsp_data     = r_rsp_data;
    assign rsp_err_mask = r_err_mask;

endmodule
